// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events, queues them
// in a small FIFO, tracks the last two make codes for a hex display, and
// counts rejected bytes.
module ps2_scan_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] disp_code0,
    output logic [7:0] disp_code1,
    output logic       overflow,
    output logic [7:0] err_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            good, bad;
    logic            emit, emit_ext, emit_brk;

    evt_t            mem_q [DEPTH];
    evt_t            mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, full;
    evt_t            head_q, head_d;
    logic            evt_valid_q, evt_valid_d;
    logic [7:0]      disp0_q, disp0_d;
    logic [7:0]      disp1_q, disp1_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      err_q, err_d;

    // Prefix decoder and idle timeout: next state, emit request, error strobe
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        good     = byte_valid && !byte_err && (byte_data != 8'h00) && (byte_data != 8'hFF);
        bad      = byte_valid && !good;

        if (byte_valid) begin
            tmo_d = '0;
            if (bad) begin
                state_d = S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (byte_data == CODE_EXT)      state_d = S_EXT;
                        else if (byte_data == CODE_BRK) state_d = S_BRK;
                        else                            emit = 1'b1;
                    end
                    S_EXT: begin
                        if (byte_data == CODE_BRK) state_d = S_EXT_BRK;
                        else if (byte_data != CODE_EXT) begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (byte_data == CODE_EXT) state_d = S_EXT_BRK;
                        else if (byte_data != CODE_BRK) begin
                            emit     = 1'b1;
                            emit_brk = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    S_EXT_BRK: begin
                        if ((byte_data != CODE_EXT) && (byte_data != CODE_BRK)) begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                            emit_brk = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            // A stalled prefix is abandoned silently; it is not a byte error
            if (tmo_q + TW'(1) == TW'(TIMEOUT)) begin
                state_d = S_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Decoder state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // Event FIFO, display shift register, sticky overflow, saturating error count
    always_comb begin
        pop      = evt_valid_q && evt_ready;
        full     = (count_q == CW'(DEPTH));
        push     = emit && (!full || pop);
        ovf_d    = ovf_q | (emit && full && !pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        disp0_d  = disp0_q;
        disp1_d  = disp1_q;
        err_d    = err_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{ext: emit_ext, brk: emit_brk, code: byte_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        // Head is taken from the post-write array, so a push into an empty
        // FIFO shows up one cycle later and never bypasses combinationally
        evt_valid_d = (count_d != '0);
        head_d      = evt_valid_d ? mem_d[rd_ptr_d] : '0;

        // The display follows every make event, even one the FIFO drops
        if (emit && !emit_brk) begin
            disp1_d = disp0_q;
            disp0_d = byte_data;
        end

        if (bad && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            evt_valid_q <= 1'b0;
            disp0_q     <= 8'h00;
            disp1_q     <= 8'h00;
            ovf_q       <= 1'b0;
            err_q       <= 8'h00;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            evt_valid_q <= evt_valid_d;
            disp0_q     <= disp0_d;
            disp1_q     <= disp1_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_code   = head_q.code;
    assign evt_ext    = head_q.ext;
    assign evt_break  = head_q.brk;
    assign disp_code0 = disp0_q;
    assign disp_code1 = disp1_q;
    assign overflow   = ovf_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: directed scenarios plus random byte traffic,
// every cycle compared against a queue-based reference model.
module tb_ps2_scan_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data  = 8'h00;
    logic       byte_err   = 1'b0;
    logic       evt_ready  = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] disp_code0;
    logic [7:0] disp_code1;
    logic       overflow;
    logic [7:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    ps2_scan_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .disp_code0 (disp_code0),
        .disp_code1 (disp_code1),
        .overflow   (overflow),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pending-prefix flags, event queue, display, counters
    logic [9:0] mq[$];
    bit         m_ext, m_brk;
    int         cyc, last_byte_cyc;
    logic [7:0] m_disp0, m_disp1, m_err;
    bit         m_ovf;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0;
        m_disp0 = 8'h00; m_disp1 = 8'h00; m_err = 8'h00;
        last_byte_cyc = cyc;
    endtask

    task automatic model_edge();
        bit pop;
        logic [7:0] d;
        pop = (mq.size() != 0) && evt_ready;
        if (pop) void'(mq.pop_front());
        d = byte_data;
        if (byte_valid) begin
            if (byte_err || d == 8'h00 || d == 8'hFF) begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                m_ext = 0; m_brk = 0;
            end else begin
                if (cyc - last_byte_cyc > int'(TIMEOUT)) begin m_ext = 0; m_brk = 0; end
                if (d == 8'hE0) m_ext = 1;
                else if (d == 8'hF0) m_brk = 1;
                else begin
                    if (mq.size() < int'(DEPTH)) mq.push_back({m_ext, m_brk, d});
                    else m_ovf = 1;
                    if (!m_brk) begin m_disp1 = m_disp0; m_disp0 = d; end
                    m_ext = 0; m_brk = 0;
                end
            end
            last_byte_cyc = cyc;
        end else if ((m_ext || m_brk) && (cyc - last_byte_cyc >= int'(TIMEOUT))) begin
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic check_all();
        logic [9:0] h;
        chk("evt_valid", 8'(evt_valid), 8'(mq.size() != 0));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("evt_code", evt_code, h[7:0]);
            chk("evt_ext", 8'(evt_ext), 8'(h[9]));
            chk("evt_break", 8'(evt_break), 8'(h[8]));
        end
        chk("disp_code0", disp_code0, m_disp0);
        chk("disp_code1", disp_code1, m_disp1);
        chk("overflow", 8'(overflow), 8'(m_ovf));
        chk("err_cnt", err_cnt, m_err);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 8'(evt_valid), 8'h00);
        chk({tag, "_code"},  evt_code, 8'h00);
        chk({tag, "_ext"},   8'(evt_ext), 8'h00);
        chk({tag, "_brk"},   8'(evt_break), 8'h00);
        chk({tag, "_disp0"}, disp_code0, 8'h00);
        chk({tag, "_disp1"}, disp_code1, 8'h00);
        chk({tag, "_ovf"},   8'(overflow), 8'h00);
        chk({tag, "_err"},   err_cnt, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        byte_valid = 1'b1; byte_data = d; byte_err = e;
        tick();
        byte_valid = 1'b0; byte_data = 8'h00; byte_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        byte_valid = 1'b0; byte_err = 1'b0; byte_data = 8'h00;
        #1;
        check_zero(tag);
        @(posedge clk); cyc++; #1;
        check_zero(tag);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] seq37 [6];
        int r;
        seq37 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        cyc = 0;
        model_reset();

        // Power-on reset
        #2;
        pulse_reset("rst0");

        // Make then break of 1C
        evt_ready = 1'b1;
        send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
        idle(3);
        chk("d35_disp0", disp_code0, 8'h1C);
        chk("d35_disp1", disp_code1, 8'h00);

        // Extended break E0 F0 75
        send(8'hE0, 0); send(8'hF0, 0);
        evt_ready = 1'b0;
        send(8'h75, 0);
        chk("d36_code", evt_code, 8'h75);
        chk("d36_flags", {6'b0, evt_ext, evt_break}, 8'h03);
        evt_ready = 1'b1;
        idle(2);

        // FIFO overflow with consumer stalled
        pulse_reset("rst1");
        evt_ready = 1'b0;
        foreach (seq37[i]) send(seq37[i], 0);
        idle(2);
        chk("d37_ovf", 8'(overflow), 8'h01);
        chk("d37_disp0", disp_code0, 8'h35);
        chk("d37_disp1", disp_code1, 8'h2C);
        chk("d37_head", evt_code, 8'h15);
        evt_ready = 1'b1;
        idle(6);
        chk("d37_ovf_sticky", 8'(overflow), 8'h01);

        // Frame error aborts a prefix; 00 is rejected
        pulse_reset("rst2");
        send(8'hE0, 0); send(8'h74, 1); send(8'h74, 0);
        send(8'h00, 0);
        idle(2);
        chk("d38_err", err_cnt, 8'h02);

        // Prefix abandoned after timeout, kept just before it
        send(8'hE0, 0); idle(TIMEOUT + 5); send(8'h6B, 0); idle(2);
        send(8'hE0, 0); idle(TIMEOUT - 5); send(8'h74, 0); idle(2);
        chk("d39_err", err_cnt, 8'h02);

        // Reset mid-sequence discards the F0 prefix
        send(8'hF0, 0);
        pulse_reset("rst3");
        send(8'h1C, 0);
        chk("d40_code", evt_code, 8'h1C);
        chk("d40_brk", 8'(evt_break), 8'h00);
        idle(2);

        // Error counter saturation
        for (int i = 0; i < 260; i++) send(8'(i), 1);
        chk("err_sat", err_cnt, 8'hFF);
        pulse_reset("rst4");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            evt_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) begin
                r = int'($urandom_range(0, 11));
                case (r)
                    0, 1:    send(8'hE0, 0);
                    2, 3:    send(8'hF0, 0);
                    4:       send(($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 0);
                    5:       send(8'($urandom_range(0, 255)), 1);
                    default: send(8'($urandom_range(1, 254)), 0);
                endcase
            end else begin
                tick();
            end
        end
        evt_ready = 1'b1;
        idle(DEPTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 1000000, meaning idle clk cycles before a partial prefix sequence is abandoned.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port byte_valid  input  1  one-cycle strobe: a PS/2 frame byte is available.
REQ-006 The block SHALL have port byte_data  input  8  received scan-code byte, qualified by byte_valid.
REQ-007 The block SHALL have port byte_err  input  1  frame error (parity/start/stop) for the byte, qualified by byte_valid.
REQ-008 The block SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-009 The block SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-010 The block SHALL have port evt_code  output  8  head event scan code.
REQ-011 The block SHALL have port evt_ext  output  1  head event carried E0 prefix.
REQ-012 The block SHALL have port evt_break  output  1  head event is a key release (F0 prefix).
REQ-013 The block SHALL have port disp_code0  output  8  most recent make code, for the hex display.
REQ-014 The block SHALL have port disp_code1  output  8  make code preceding disp_code0.
REQ-015 The block SHALL have port overflow  output  1  sticky: an event was dropped due to a full FIFO.
REQ-016 The block SHALL have port err_cnt  output  8  saturating count of rejected bytes.

Function
REQ-017 A byte SHALL be "good" when byte_valid=1, byte_err=0, and byte_data is neither 8'h00 nor 8'hFF; otherwise, if byte_valid=1, it SHALL be "bad".
REQ-018 FSM states SHALL be IDLE, EXT, BRK, EXT_BRK.
REQ-019 IDLE: good E0 -> EXT; good F0 -> BRK; any other good byte -> emit {ext=0, brk=0}, stay in IDLE.
REQ-020 EXT: good F0 -> EXT_BRK; good E0 -> stay; any other good byte -> emit {ext=1, brk=0}, -> IDLE.
REQ-021 BRK: good E0 -> EXT_BRK; good F0 -> stay; any other good byte -> emit {ext=0, brk=1}, -> IDLE.
REQ-022 EXT_BRK: good E0/F0 -> stay; any other good byte -> emit {ext=1, brk=1}, -> IDLE.
REQ-023 A bad byte in any state SHALL force IDLE, emit nothing, and increment err_cnt, saturating at 8'hFF.
REQ-024 Timeout counter SHALL clear on every byte_valid and count only while not in IDLE; on reaching TIMEOUT the FSM SHALL return to IDLE with no event and err_cnt unchanged.
REQ-025 An emit SHALL push {ext, brk, code} into the FIFO on the clk edge that samples the byte; evt_valid SHALL rise the next cycle if the FIFO was empty (latency 1).
REQ-026 Outputs evt_code/evt_ext/evt_break SHALL reflect the FIFO head whenever evt_valid=1; a pop SHALL occur when evt_valid & evt_ready.
REQ-027 Head and outputs SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-028 Push to a full FIFO with a simultaneous pop SHALL succeed; push to a full FIFO without a pop SHALL drop the event and set overflow.
REQ-029 Push and pop on an empty FIFO SHALL NOT bypass: the event appears on the next cycle.
REQ-030 Pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra pointer bit or an occupancy counter.
REQ-031 Each emitted make event (brk=0) SHALL shift disp_code1<=disp_code0 and load disp_code0<=code, even if the event is dropped; break events SHALL NOT touch the display.
REQ-032 overflow SHALL clear only on reset.

Reset
REQ-033 While rst=1: FSM in IDLE, FIFO empty, evt_valid=0, evt_code=8'h00, evt_ext=0, evt_break=0, disp_code0/1=8'h00, overflow=0, err_cnt=0, timeout counter=0.
REQ-034 Reset asserted mid-sequence (e.g. after E0) SHALL discard the prefix and the FIFO contents; the first good byte after release SHALL be decoded from IDLE.

Verification
REQ-035 Bytes 1C, F0 1C with evt_ready=1 -> events {1C,0,0} then {1C,0,1}; disp_code0=1C, disp_code1=00.
REQ-036 Bytes E0 F0 75 -> one event {75,1,1}; no event for E0 or F0; disp unchanged.
REQ-037 evt_ready=0, DEPTH=4, six make codes 15,1D,24,2D,2C,35 -> FIFO holds 15,1D,24,2D; overflow=1; disp_code0=35, disp_code1=2C.
REQ-038 E0 then byte_err=1 byte, then 74 -> err_cnt=1, event {74,0,0}; byte 00 -> err_cnt=2, no event.
REQ-039 E0, then no byte for TIMEOUT cycles, then 6B -> event {6B,0,0}; err_cnt unchanged.
REQ-040 rst pulse after F0, then 1C -> event {1C,0,0}; all outputs zero during reset.
